// File: rtl/branch_pkg.sv
// Shared types and encodings for branch resolution and the branch history table.
package branch_pkg;

  typedef enum logic [2:0] {
    PCS_PLUS4   = 3'd0,
    PCS_JALR    = 3'd1,
    PCS_BRANCH  = 3'd2,
    PCS_JAL     = 3'd3,
    PCS_RECOVER = 3'd4
  } pcsrc_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_WNT = 2'b01;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: combinational read port, one saturating write port.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_taken,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic                     wr_taken
);

  logic [1:0] ctr [DEPTH];

  // NOTE: the table is a flop array, so every entry is reset; predictions must be
  // deterministic from the first fetch after reset, which an SRAM could not give.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_WNT;
    end else if (wr_en) begin
      ctr[wr_idx] <= ctr_step(ctr[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-update value when the same entry is written this cycle.
  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch/jump resolution with a registered PC-source/redirect,
// BHT training and saturating branch/mispredict counters.
module branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  IF_PC,
  output logic             IF_PRED_TAKEN,
  input  logic             EX_VALID,
  input  logic             EX_STALL,
  input  logic [31:0]      EX_IR,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic [XLEN-1:0]  EX_RS1,
  input  logic [XLEN-1:0]  EX_RS2,
  input  logic             EX_PRED_TAKEN,
  output logic [2:0]       PC_SOURCE_OUT,
  output logic             REDIRECT,
  output logic [XLEN-1:0]  RECOVER_PC,
  output logic [CNT_W-1:0] BR_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       is_branch;
  logic       legal_branch;
  logic       cond_taken;
  logic       sample;
  logic       miss;
  pcsrc_e     pcs_nxt;

  pcsrc_e          pc_source_q;
  logic            redirect_q;
  logic [XLEN-1:0] recover_pc_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] miss_count_q;

  assign opcode       = EX_IR[6:0];
  assign f3           = EX_IR[14:12];
  assign is_branch    = (opcode == OP_BRANCH);
  assign legal_branch = is_branch && (f3 != 3'b010) && (f3 != 3'b011);
  assign sample       = EX_VALID && !EX_STALL;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cond_taken = 1'b0;
    case (f3)
      F3_BEQ:  cond_taken = (EX_RS1 == EX_RS2);
      F3_BNE:  cond_taken = (EX_RS1 != EX_RS2);
      F3_BLT:  cond_taken = ($signed(EX_RS1) <  $signed(EX_RS2));
      F3_BGE:  cond_taken = ($signed(EX_RS1) >= $signed(EX_RS2));
      F3_BLTU: cond_taken = (EX_RS1 <  EX_RS2);
      F3_BGEU: cond_taken = (EX_RS1 >= EX_RS2);
      default: cond_taken = 1'b0;
    endcase
  end

  // Illegal funct3 is a not-taken branch: it still corrects a taken prediction
  // but is neither trained nor counted.
  always_comb begin
    pcs_nxt = PCS_PLUS4;
    miss    = 1'b0;
    if (EX_VALID) begin
      if (opcode == OP_JAL) begin
        pcs_nxt = PCS_JAL;
        miss    = 1'b1;
      end else if (opcode == OP_JALR) begin
        pcs_nxt = PCS_JALR;
        miss    = 1'b1;
      end else if (is_branch) begin
        if (cond_taken && !EX_PRED_TAKEN)      pcs_nxt = PCS_BRANCH;
        else if (!cond_taken && EX_PRED_TAKEN) pcs_nxt = PCS_RECOVER;
        miss = legal_branch && (cond_taken != EX_PRED_TAKEN);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_source_q  <= PCS_PLUS4;
      redirect_q   <= 1'b0;
      recover_pc_q <= '0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (!EX_STALL) begin
      pc_source_q <= pcs_nxt;
      redirect_q  <= (pcs_nxt != PCS_PLUS4);
      if (EX_VALID) recover_pc_q <= EX_PC + XLEN'(4);
      if (EX_VALID && legal_branch && (br_count_q != '1))
        br_count_q <= br_count_q + CNT_W'(1);
      if (miss && (miss_count_q != '1))
        miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end

  bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (IF_PC[IDX_W+1:2]),
    .rd_taken (IF_PRED_TAKEN),
    .wr_en    (sample && legal_branch),
    .wr_idx   (EX_PC[IDX_W+1:2]),
    .wr_taken (cond_taken)
  );

  assign PC_SOURCE_OUT = pc_source_q;
  assign REDIRECT      = redirect_q;
  assign RECOVER_PC    = recover_pc_q;
  assign BR_COUNT      = br_count_q;
  assign MISS_COUNT    = miss_count_q;

  logic unused_bits;
  assign unused_bits = ^{EX_IR[31:15], EX_IR[11:7], IF_PC[XLEN-1:IDX_W+2], IF_PC[1:0]};

endmodule
